// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus of the BIST controller: strobes, address and data in both directions.
// The controller drives it through the master modport; the memory sits on the slave side.
interface mem_bist_ctrl_if #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8
);
   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;

   modport master (
      output read,
      output write,
      output addr,
      output data_in,
      input  data_out
   );

   modport slave (
      input  read,
      input  write,
      input  addr,
      input  data_in,
      output data_out
   );
endinterface

// File: rtl/mem_bist_ctrl.sv
// March-style BIST: clear/read-zero pass, then write-address/read-address pass, mismatches counted.
// Optional first-failure log is built only when MEM_BIST_FAIL_LOG_EN is defined.
module mem_bist_ctrl #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_fail_addr,
   output logic [DATA_W-1:0] first_fail_data,
   mem_bist_ctrl_if.master   mem
);

   typedef enum logic [2:0] {
      StIdle, StWrZero, StRdZero, StDrain0, StWrAddr, StRdAddr, StDrain1, StDone
   } state_e;

   localparam logic [ADDR_W-1:0] LastAddr = '1;
   localparam logic [ERR_W-1:0]  ErrMax   = '1;

   state_e            state_q, state_d;
   logic              read_q, read_d;
   logic              write_q, write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_in_q, data_in_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [DATA_W-1:0] exp_q, exp_d;
   logic              vld_q, vld_d;
   logic              start_acc;
   logic              mismatch;
   logic              last;

   // Compare stage: the read issued last cycle has its data on data_out now.
   always_comb begin
      start_acc = start && ((state_q == StIdle) || (state_q == StDone));
      mismatch  = vld_q && (mem.data_out != exp_q);
      vld_d     = read_q;
      exp_d     = (state_q == StRdAddr) ? DATA_W'(addr_q) : '0;
      err_d     = err_q;
      if (start_acc) begin
         err_d = '0;
      end else if (mismatch && (err_q != ErrMax)) begin
         err_d = err_q + ERR_W'(1);
      end
   end

   always_comb begin
      last      = (addr_q == LastAddr);
      state_d   = state_q;
      addr_d    = addr_q;
      read_d    = 1'b0;
      write_d   = 1'b0;
      data_in_d = '0;
      busy_d    = busy_q;
      done_d    = done_q;
      pass_d    = pass_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d = StWrZero;
               addr_d  = '0;
               write_d = 1'b1;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         StWrZero: begin
            if (last) begin
               state_d = StRdZero;
               addr_d  = '0;
               read_d  = 1'b1;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               write_d = 1'b1;
            end
         end
         StRdZero: begin
            if (last) begin
               state_d = StDrain0;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               read_d = 1'b1;
            end
         end
         StDrain0: begin
            state_d   = StWrAddr;
            addr_d    = '0;
            write_d   = 1'b1;
            data_in_d = '0;
         end
         StWrAddr: begin
            if (last) begin
               state_d = StRdAddr;
               addr_d  = '0;
               read_d  = 1'b1;
            end else begin
               addr_d    = addr_q + ADDR_W'(1);
               write_d   = 1'b1;
               data_in_d = DATA_W'(addr_q + ADDR_W'(1));
            end
         end
         StRdAddr: begin
            if (last) begin
               state_d = StDrain1;
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
               read_d = 1'b1;
            end
         end
         StDrain1: begin
            // Final compare resolves on this edge, so pass looks at the updated count.
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= '0;
         data_in_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         err_q     <= '0;
         exp_q     <= '0;
         vld_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         read_q    <= read_d;
         write_q   <= write_d;
         addr_q    <= addr_d;
         data_in_q <= data_in_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pass_q    <= pass_d;
         err_q     <= err_d;
         exp_q     <= exp_d;
         vld_q     <= vld_d;
      end
   end

`ifdef MEM_BIST_FAIL_LOG_EN
   logic              logged_q, logged_d;
   logic [ADDR_W-1:0] cmp_addr_q;
   logic [ADDR_W-1:0] ffa_q, ffa_d;
   logic [DATA_W-1:0] ffd_q, ffd_d;

   always_comb begin
      logged_d = logged_q;
      ffa_d    = ffa_q;
      ffd_d    = ffd_q;
      if (start_acc) begin
         logged_d = 1'b0;
         ffa_d    = '0;
         ffd_d    = '0;
      end else if (mismatch && !logged_q) begin
         logged_d = 1'b1;
         ffa_d    = cmp_addr_q;
         ffd_d    = mem.data_out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         logged_q   <= 1'b0;
         cmp_addr_q <= '0;
         ffa_q      <= '0;
         ffd_q      <= '0;
      end else begin
         logged_q   <= logged_d;
         cmp_addr_q <= addr_q;
         ffa_q      <= ffa_d;
         ffd_q      <= ffd_d;
      end
   end

   assign first_fail_addr = ffa_q;
   assign first_fail_data = ffd_q;
`else
   assign first_fail_addr = '0;
   assign first_fail_data = '0;
`endif

   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign err_count    = err_q;
   assign mem.read     = read_q;
   assign mem.write    = write_q;
   assign mem.addr     = addr_q;
   assign mem.data_in  = data_in_q;

endmodule
